// File: rtl/elbeth_alu_issue.sv
// Decode/execute issue slot: decodes one RV32I integer instruction into ALU
// operation and operands, held in a single registered slot with valid/ready.
module elbeth_alu_issue #(
  parameter int          XLEN         = 32,
  parameter logic [31:0] RESET_PC_TAG = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [31:0]     in_pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            stall,
  input  logic            flush,
  output logic            out_valid,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_op,
  output logic [4:0]      rd_addr,
  output logic            rd_we,
  output logic            illegal,
  output logic [31:0]     out_pc
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SLL  = 4'd2;
  localparam logic [3:0] OP_SLT  = 4'd3;
  localparam logic [3:0] OP_SLTU = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_OR   = 4'd8;
  localparam logic [3:0] OP_AND  = 4'd9;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Handshake: a transfer happens on a rising edge where in_valid && in_ready.
  // in_ready depends only on slot state and stall, never on in_valid; the
  // slot presents out_valid and holds every output while stall is high.
  assign in_ready = !out_valid || !stall;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [4:0]      rd_field;
  logic [31:0]     imm_i;
  logic [31:0]     imm_u;
  logic [31:0]     shamt;
  logic            f7_ok;
  logic            is_shift;

  logic [XLEN-1:0] dec_a;
  logic [XLEN-1:0] dec_b;
  logic [3:0]      dec_op;
  logic            dec_ill;
  logic            dec_we;

  assign opcode   = in_instr[6:0];
  assign funct3   = in_instr[14:12];
  assign funct7   = in_instr[31:25];
  assign rd_field = in_instr[11:7];
  assign imm_i    = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_u    = {in_instr[31:12], 12'b0};
  assign shamt    = {27'b0, in_instr[24:20]};
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

  // funct7 qualifier shared by OP and the OP-IMM shifts; the alternate
  // encoding only exists for SUB (OP) and SRA/SRAI.
  always_comb begin
    f7_ok = 1'b0;
    if (funct7 == F7_BASE)
      f7_ok = 1'b1;
    else if (funct7 == F7_ALT)
      f7_ok = (funct3 == 3'b101) || ((funct3 == 3'b000) && (opcode == OPC_OP));
  end

  always_comb begin
    dec_a   = '0;
    dec_b   = '0;
    dec_op  = OP_ADD;
    dec_ill = 1'b0;
    unique case (opcode)
      OPC_OP: begin
        dec_a   = rs1_data;
        dec_b   = rs2_data;
        dec_ill = !f7_ok;
        unique case (funct3)
          3'b000:  dec_op = funct7[5] ? OP_SUB : OP_ADD;
          3'b001:  dec_op = OP_SLL;
          3'b010:  dec_op = OP_SLT;
          3'b011:  dec_op = OP_SLTU;
          3'b100:  dec_op = OP_XOR;
          3'b101:  dec_op = funct7[5] ? OP_SRA : OP_SRL;
          3'b110:  dec_op = OP_OR;
          default: dec_op = OP_AND;
        endcase
      end
      OPC_OP_IMM: begin
        dec_a   = rs1_data;
        dec_b   = is_shift ? shamt : imm_i;
        dec_ill = is_shift && !f7_ok;
        unique case (funct3)
          3'b000:  dec_op = OP_ADD;
          3'b001:  dec_op = OP_SLL;
          3'b010:  dec_op = OP_SLT;
          3'b011:  dec_op = OP_SLTU;
          3'b100:  dec_op = OP_XOR;
          3'b101:  dec_op = funct7[5] ? OP_SRA : OP_SRL;
          3'b110:  dec_op = OP_OR;
          default: dec_op = OP_AND;
        endcase
      end
      OPC_LUI: begin
        dec_b = imm_u;
      end
      OPC_AUIPC: begin
        dec_a = in_pc;
        dec_b = imm_u;
      end
      default: dec_ill = 1'b1;
    endcase
    // Illegal encodings present a neutral ADD of zeros to the ALU.
    if (dec_ill) begin
      dec_a  = '0;
      dec_b  = '0;
      dec_op = OP_ADD;
    end
  end

  assign dec_we = !dec_ill && (rd_field != 5'd0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= OP_ADD;
      rd_addr   <= '0;
      rd_we     <= 1'b0;
      illegal   <= 1'b0;
      out_pc    <= RESET_PC_TAG;
    end else if (flush) begin
      out_valid <= 1'b0;
      rd_we     <= 1'b0;
    end else if (in_valid && in_ready) begin
      out_valid <= 1'b1;
      alu_a     <= dec_a;
      alu_b     <= dec_b;
      alu_op    <= dec_op;
      rd_addr   <= rd_field;
      rd_we     <= dec_we;
      illegal   <= dec_ill;
      out_pc    <= in_pc;
    end else if (!stall) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_elbeth_alu_issue.sv
// Directed bench for elbeth_alu_issue: hand-computed decode results checked
// with immediate assertions one cycle after each acceptance.
module tb_elbeth_alu_issue;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SLL  = 4'd2;
  localparam logic [3:0] OP_SLTU = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        stall;
  logic        flush;
  logic        out_valid;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_op;
  logic [4:0]  rd_addr;
  logic        rd_we;
  logic        illegal;
  logic [31:0] out_pc;

  int errors = 0;
  int checks = 0;

  elbeth_alu_issue #(.XLEN(32), .RESET_PC_TAG(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .rs1_data(rs1_data),
    .rs2_data(rs2_data), .stall(stall), .flush(flush),
    .out_valid(out_valid), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .rd_addr(rd_addr), .rd_we(rd_we), .illegal(illegal), .out_pc(out_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_slot(input string tag, input logic v, input logic [31:0] a,
                          input logic [31:0] b, input logic [3:0] op,
                          input logic [4:0] rd, input logic we, input logic ill);
    chk({tag, ".valid"},   {31'b0, out_valid}, {31'b0, v});
    chk({tag, ".alu_a"},   alu_a, a);
    chk({tag, ".alu_b"},   alu_b, b);
    chk({tag, ".alu_op"},  {28'b0, alu_op}, {28'b0, op});
    chk({tag, ".rd_addr"}, {27'b0, rd_addr}, {27'b0, rd});
    chk({tag, ".rd_we"},   {31'b0, rd_we}, {31'b0, we});
    chk({tag, ".illegal"}, {31'b0, illegal}, {31'b0, ill});
  endtask

  task automatic offer(input logic [31:0] instr, input logic [31:0] pc,
                       input logic [31:0] r1, input logic [31:0] r2);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
    rs1_data = r1;
    rs2_data = r2;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_instr = 32'h0; in_pc = 32'h0;
    rs1_data = 32'h0; rs2_data = 32'h0; stall = 1'b0; flush = 1'b0;
    step(); step();
    chk_slot("reset", 1'b0, 32'h0, 32'h0, OP_ADD, 5'd0, 1'b0, 1'b0);
    chk("reset.out_pc", out_pc, 32'h0);
    chk("reset.in_ready", {31'b0, in_ready}, 32'h1);
    rst_n = 1'b1;

    // ADD x3,x1,x2
    offer(32'h002081B3, 32'h40, 32'd5, 32'd7);
    step();
    chk_slot("add", 1'b1, 32'd5, 32'd7, OP_ADD, 5'd3, 1'b1, 1'b0);
    chk("add.out_pc", out_pc, 32'h40);

    // ADDI x1,x0,-1 then SRAI x2,x1,4 back to back
    offer(32'hFFF00093, 32'h44, 32'h0, 32'h55);
    step();
    chk_slot("addi", 1'b1, 32'h0, 32'hFFFFFFFF, OP_ADD, 5'd1, 1'b1, 1'b0);
    offer(32'h4040D113, 32'h48, 32'hFFFFFFFF, 32'h0);
    step();
    chk_slot("srai", 1'b1, 32'hFFFFFFFF, 32'd4, OP_SRA, 5'd2, 1'b1, 1'b0);

    // Stall with full slot while upstream keeps offering and rs1 changes
    stall = 1'b1;
    offer(32'h002081B3, 32'h4C, 32'd100, 32'd9);
    #1;
    chk("stall.in_ready", {31'b0, in_ready}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      rs1_data = 32'd200 + i;
      step();
      chk_slot("stall_hold", 1'b1, 32'hFFFFFFFF, 32'd4, OP_SRA, 5'd2, 1'b1, 1'b0);
      chk("stall_hold.out_pc", out_pc, 32'h48);
      chk("stall_hold.in_ready", {31'b0, in_ready}, 32'h0);
    end
    stall = 1'b0;
    // XOR x4,x1,x2
    offer(32'h0020C233, 32'h4C, 32'h0000F0F0, 32'h00000FF0);
    #1;
    chk("release.in_ready", {31'b0, in_ready}, 32'h1);
    step();
    chk_slot("xor", 1'b1, 32'h0000F0F0, 32'h00000FF0, OP_XOR, 5'd4, 1'b1, 1'b0);

    // SUB x3,x1,x2 and SRL x5,x6,x7 with full-width rs2
    offer(32'h402081B3, 32'h50, 32'd10, 32'd3);
    step();
    chk_slot("sub", 1'b1, 32'd10, 32'd3, OP_SUB, 5'd3, 1'b1, 1'b0);
    offer(32'h007352B3, 32'h54, 32'h80000000, 32'hFFFFFF21);
    step();
    chk_slot("srl", 1'b1, 32'h80000000, 32'hFFFFFF21, OP_SRL, 5'd5, 1'b1, 1'b0);

    // SLTIU x6,x1,0x7FF and SLLI x1,x1,1
    offer(32'h7FF0B313, 32'h58, 32'h3, 32'h0);
    step();
    chk_slot("sltiu", 1'b1, 32'h3, 32'h000007FF, OP_SLTU, 5'd6, 1'b1, 1'b0);
    offer(32'h00109093, 32'h5C, 32'h11, 32'h0);
    step();
    chk_slot("slli", 1'b1, 32'h11, 32'd1, OP_SLL, 5'd1, 1'b1, 1'b0);

    // AUIPC x5,0x12345 at pc 0x100, then LUI x0,0xABCDE
    offer(32'h12345297, 32'h100, 32'hDEAD, 32'hBEEF);
    step();
    chk_slot("auipc", 1'b1, 32'h100, 32'h12345000, OP_ADD, 5'd5, 1'b1, 1'b0);
    chk("auipc.out_pc", out_pc, 32'h100);
    offer(32'hABCDE037, 32'h104, 32'hDEAD, 32'hBEEF);
    step();
    chk_slot("lui_x0", 1'b1, 32'h0, 32'hABCDE000, OP_ADD, 5'd0, 1'b0, 1'b0);

    // Illegal: unknown opcode, OP with funct7=0000001, SLLI with funct7=0100000
    offer(32'h0000007F, 32'h108, 32'h1234, 32'h5678);
    step();
    chk_slot("bad_opcode", 1'b1, 32'h0, 32'h0, OP_ADD, 5'd0, 1'b0, 1'b1);
    offer(32'h022081B3, 32'h10C, 32'h1234, 32'h5678);
    step();
    chk_slot("bad_funct7", 1'b1, 32'h0, 32'h0, OP_ADD, 5'd3, 1'b0, 1'b1);
    offer(32'h40109093, 32'h110, 32'h1234, 32'h5678);
    step();
    chk_slot("bad_slli", 1'b1, 32'h0, 32'h0, OP_ADD, 5'd1, 1'b0, 1'b1);

    // No offer, no stall: slot drains
    in_valid = 1'b0;
    step();
    chk("drain.valid", {31'b0, out_valid}, 32'h0);
    chk("drain.in_ready", {31'b0, in_ready}, 32'h1);

    // Flush kills the full slot and drops the concurrent offer
    offer(32'h002081B3, 32'h200, 32'd1, 32'd2);
    step();
    chk("preflush.valid", {31'b0, out_valid}, 32'h1);
    flush = 1'b1;
    offer(32'h0020C233, 32'h204, 32'd3, 32'd4);
    step();
    chk("flush.valid", {31'b0, out_valid}, 32'h0);
    chk("flush.rd_we", {31'b0, rd_we}, 32'h0);
    chk("flush.alu_a", alu_a, 32'd1);
    flush = 1'b0;
    in_valid = 1'b0;
    step();
    chk("postflush.valid", {31'b0, out_valid}, 32'h0);

    // Reset while stalled and full
    offer(32'h002081B3, 32'h300, 32'd8, 32'd9);
    step();
    stall = 1'b1;
    step();
    chk_slot("stall_full", 1'b1, 32'd8, 32'd9, OP_ADD, 5'd3, 1'b1, 1'b0);
    rst_n = 1'b0;
    step();
    chk_slot("reset_mid", 1'b0, 32'h0, 32'h0, OP_ADD, 5'd0, 1'b0, 1'b0);
    chk("reset_mid.out_pc", out_pc, 32'h0);
    rst_n = 1'b1;
    stall = 1'b0;
    in_valid = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/elbeth_alu_issue.md
Name: elbeth_alu_issue

Overview:
- Issue stage feeding the Elbeth execution unit: decodes one RV32I integer instruction per cycle into the ALU operation code, both ALU operands, and destination-register controls.
- Holds the result in a registered decode/execute pipeline slot with a valid/ready handshake, stall and flush.
- Sits between register-file read and the ALU; its outputs connect directly to the ALU data_a/data_b/operation inputs.
- Operation codes are the OP_* encodings from elbeth_definitions.v.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- RESET_PC_TAG, 32'h0000_0000, value held on out_pc during reset.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  upstream has an instruction.
- in_ready  output  1  slot can accept this cycle.
- in_instr  input  32  instruction word.
- in_pc  input  32  instruction address.
- rs1_data  input  32  register-file value for rs1.
- rs2_data  input  32  register-file value for rs2.
- stall  input  1  downstream cannot consume the slot.
- flush  input  1  kill slot contents (branch/exception).
- out_valid  output  1  slot holds a decoded instruction.
- alu_a  output  32  ALU data_a.
- alu_b  output  32  ALU data_b.
- alu_op  output  4  ALU operation code (OP_*).
- rd_addr  output  5  destination register.
- rd_we  output  1  write-back enable.
- illegal  output  1  unsupported or illegal encoding in slot.
- out_pc  output  32  PC of slot instruction.

Behaviour:
- Reset: on a clk edge with rst_n=0, all outputs are cleared: out_valid=0, alu_a=0, alu_b=0, alu_op=OP_ADD, rd_addr=0, rd_we=0, illegal=0, out_pc=RESET_PC_TAG. Reset overrides flush, stall and load. Reset mid-operation discards the slot.
- Handshake:
  - in_ready = !out_valid || !stall (combinational).
  - Load when in_valid && in_ready. Latency is one cycle: outputs are valid on the edge after acceptance.
  - When out_valid && !stall && !(in_valid && in_ready), the slot empties: out_valid becomes 0.
  - When stall && out_valid, all outputs hold.
- Flush: highest priority after reset. out_valid becomes 0 and rd_we becomes 0. An instruction offered in the same cycle is dropped.
- Decode, by opcode in_instr[6:0]:
  - OP (0110011): a=rs1, b=rs2.
    - funct3/funct7 map: 000/0000000 ADD, 000/0100000 SUB, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101/0000000 SRL, 101/0100000 SRA, 110 OR, 111 AND.
    - For register shifts, b is the full rs2 value; the ALU uses the low bits.
  - OP-IMM (0010011): a=rs1, b=sign-extended I-immediate.
    - Same funct3 map; SUB does not exist here.
    - SLLI/SRLI/SRAI: b = {27'b0, instr[24:20]}.
    - funct7 must be 0000000, or 0100000 for SRAI only; any other value is illegal.
  - LUI (0110111): a=0, b={instr[31:12],12'b0}, op=ADD.
  - AUIPC (0010111): a=in_pc, b={instr[31:12],12'b0}, op=ADD.
  - Any other opcode, or an illegal funct combination: illegal=1, rd_we=0, op=OP_ADD, a=b=0; out_valid still asserts so the trap logic sees it.
- rd_addr = instr[11:7]. rd_we = 1 for legal instructions with rd != 0. Writes to x0 give rd_we=0, but alu_a, alu_b and alu_op are still driven.
- Operands are captured at acceptance. Changes on rs1_data/rs2_data while stalled do not affect the slot; forwarding is upstream's job.
- No output is ever X; no combinational path exists from in_* to out_* or alu_*.

Test Plan:
1. Reset, then ADD x3,x1,x2 (32'h002081B3) with rs1=5, rs2=7 -> next edge: out_valid=1, alu_op=OP_ADD, alu_a=5, alu_b=7, rd_addr=3, rd_we=1, illegal=0.
2. ADDI x1,x0,-1 (32'hFFF00093) then SRAI x2,x1,4 (32'h4040D113) back-to-back with stall=0 -> first alu_b=32'hFFFFFFFF; second alu_op=OP_SRA, alu_b=4; out_valid stays 1 across both edges.
3. Stall for 3 cycles with the slot full, in_valid=1 and rs1_data changing -> in_ready=0; all outputs hold their values; release -> new instruction loads on the next edge.
4. AUIPC x5,0x12345 (32'h12345297) at in_pc=32'h100 -> alu_a=32'h100, alu_b=32'h12345000, op=OP_ADD; LUI with rd=x0 -> rd_we=0.
5. Opcode 1111111, and OP with funct7=0000001 -> illegal=1, rd_we=0, alu_a=alu_b=0, out_valid=1.
6. flush together with in_valid=1 -> out_valid=0. rst_n=0 while stalled and full -> all outputs return to reset values on that edge.
